ahb_lite_ram: RTL
=================

# ahb_lite_ram

AHB-Lite responder exposing a single-port on-chip block RAM to one SCR1 memory port (imem or dmem), replacing ad-hoc ROM/RAM glue in board tops. It accepts single and back-to-back transfers with zero wait states and supports byte, halfword and word writes with byte-lane strobing. It forwards pending-write data to an immediately following read, and reports misaligned or oversized transfers with a two-cycle ERROR response. It is the responder counterpart to the SCR1 core's AHB initiator, decoded by an external HSEL.

## Interface
- ADDR_WIDTH, 15: byte-address bits used; RAM depth = 2^(ADDR_WIDTH-2) 32-bit words.
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select, valid in address phase.
- HADDR  in  32  byte address; bits above ADDR_WIDTH-1 ignored.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word; >2 is an error.
- HBURST  in  3  ignored (every beat handled as a single transfer).
- HPROT  in  4  ignored.
- HWDATA  in  32  write data, valid in data phase, standard little-endian lanes.
- HRDATA  out  32  read data, full word, valid when HREADY=1 in read data phase.
- HREADY  out  1  transfer complete / slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

## Operation
- Transfer accepted on a rising edge when HSEL=1, HTRANS[1]=1 and HREADY=1. Otherwise (IDLE, BUSY, HSEL=0) no access is made and the next cycle is OKAY with HREADY=1.
- Word index = HADDR[ADDR_WIDTH-1:2]. Upper address bits alias (wrap modulo 2^ADDR_WIDTH).
- Byte mask from HSIZE/HADDR[1:0]:
  - byte: bit HADDR[1:0].
  - half: 0011 when HADDR[1]=0, 1100 otherwise.
  - word: 1111.
- Error conditions:
  - half with HADDR[0]=1.
  - word with HADDR[1:0]!=0.
  - HSIZE>2.
  - An errored transfer performs no RAM access.
- FSM states:
  - DATA_OK: default and reset state; covers both no-transfer and a data phase in progress.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- FSM transitions:
  - Accepted error transfer → ERR1 → ERR2 → DATA_OK.
  - Transfers are not accepted in ERR1. A transfer presented during ERR2 is accepted normally.
- Write:
  - Address, mask and word index are latched in the address phase.
  - HWDATA is sampled at the end of the data phase.
  - Only masked lanes are written to RAM on that edge.
  - The write remains recorded as "last write" (index, mask, data) until the next write.
- Read:
  - RAM is read synchronously, addressed from HADDR in the address phase.
  - HRDATA = RAM output in the data phase.
- Read-after-write forwarding: if a read's address phase coincides with the data phase of a write to the same word index, the RAM returns old data. HRDATA must then be the RAM word with the write's masked lanes replaced by that cycle's HWDATA lanes.
- HRDATA holds its last value outside read data phases; it is not reset to zero except by HRESETn.
- RAM contents are not reset.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, state DATA_OK, no pending write, last-write record invalid.
- Reads:
  - Zero wait states: address phase cycle N, HRDATA valid with HREADY=1 in cycle N+1.
  - Back-to-back reads: one word per cycle.
- Writes:
  - Zero wait states: address phase N, data phase N+1, RAM updated at the end of N+1.
  - A read whose address phase is N+2 or later reads the RAM directly.
- Write → read of the same word in consecutive cycles: forwarded, no stall.
- Write → write and read → write: one per cycle, no stall.
- Error: address phase N; cycle N+1 ERR1 (HREADY=0, HRESP=1); cycle N+2 ERR2 (HREADY=1, HRESP=1); normal from N+3.
- HRESETn asserted at any point:
  - An in-flight write whose data phase has not completed is discarded.
  - Outputs go to reset values asynchronously.
  - The FSM returns to DATA_OK.

## Test plan
- Word write 0xDEADBEEF to 0x10, idle cycle, word read 0x10 → HRDATA=0xDEADBEEF one cycle after the read address phase, HRESP=0, HREADY always 1.
- Byte write 0xA5 (lane 1) to 0x11 after the above, then read 0x10 → 0xDEADA5EF. Halfword write 0x1234 to 0x12, then read → 0x1234A5EF.
- Back-to-back: write word 0x11223344 to 0x20 with a read of 0x20 in its data phase → read returns 0x11223344. Byte write 0xFF to 0x23 followed directly by a read → 0xFF223344.
- Misaligned word read at 0x02 and halfword write at 0x21 → each gives HREADY=0/HRESP=1, then HREADY=1/HRESP=1. Subsequent read of 0x20 is unchanged.
- ADDR_WIDTH=15: write 0xCAFEF00D to 0x8004, read 0x0004 → 0xCAFEF00D. IDLE/BUSY transfers and HSEL=0 cycles cause no writes.
- Assert HRESETn during a write's data phase to 0x30 (previous value 0x0) → after reset, read 0x30 returns 0x0; HRDATA=0, HREADY=1, HRESP=0 while in reset.

Source files
------------

// File: rtl/ahb_lite_ram.sv
// AHB-Lite responder in front of a single-port block RAM: zero-wait reads/writes,
// byte-lane strobes, write-to-read forwarding and a two-cycle ERROR response.
module ahb_lite_ram #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    DATA_OK = 2'd0,
    ERR1    = 2'd1,
    ERR2    = 2'd2
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'd0:    lane_mask = 4'b0001 << lsb;
      3'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'd0:    size_err = 1'b0;
      3'd1:    size_err = lsb[0];
      3'd2:    size_err = (lsb != 2'b00);
      default: size_err = 1'b1;
    endcase
  endfunction

  logic [31:0]      mem_r [DEPTH];
  state_t           state_r, state_nxt_s;
  logic             hready_r, hresp_r, hready_nxt_s, hresp_nxt_s;
  logic [31:0]      hrdata_r, rd_word_s;
  logic             accept_s, err_s, good_s;
  logic [IDX_W-1:0] idx_s;
  logic [3:0]       mask_s;
  // wr_idx_r/wr_mask_r persist as the last-write record; wr_pend_r marks its data phase
  logic             wr_pend_r;
  logic [IDX_W-1:0] wr_idx_r;
  logic [3:0]       wr_mask_r;
  logic             unused_s;

  assign unused_s = ^{HBURST, HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH]};

  assign accept_s = HSEL & HTRANS[1] & hready_r;
  assign err_s    = size_err(HSIZE, HADDR[1:0]);
  assign good_s   = accept_s & ~err_s;
  assign idx_s    = HADDR[ADDR_WIDTH-1:2];
  assign mask_s   = lane_mask(HSIZE, HADDR[1:0]);

  assign HRDATA = hrdata_r;
  assign HREADY = hready_r;
  assign HRESP  = hresp_r;

  // Next-state decode for the error response sequencer and its registered outputs
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DATA_OK: begin
        if (accept_s && err_s) state_nxt_s = ERR1;
        else                   state_nxt_s = DATA_OK;
      end
      ERR1:    state_nxt_s = ERR2;
      ERR2: begin
        if (accept_s && err_s) state_nxt_s = ERR1;
        else                   state_nxt_s = DATA_OK;
      end
      default: state_nxt_s = DATA_OK;
    endcase
    hready_nxt_s = (state_nxt_s != ERR1);
    hresp_nxt_s  = (state_nxt_s != DATA_OK);
  end

  // Read word: RAM contents, with lanes of a write in its data phase substituted
  always_comb begin
    rd_word_s = mem_r[idx_s];
    for (int i = 0; i < 4; i++) begin
      if (wr_pend_r && (wr_idx_r == idx_s) && wr_mask_r[i]) begin
        rd_word_s[8*i +: 8] = HWDATA[8*i +: 8];
      end else begin
        rd_word_s[8*i +: 8] = mem_r[idx_s][8*i +: 8];
      end
    end
  end

  // Control state, pending write, and registered bus outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r   <= DATA_OK;
      hready_r  <= 1'b1;
      hresp_r   <= 1'b0;
      hrdata_r  <= 32'h0000_0000;
      wr_pend_r <= 1'b0;
      wr_idx_r  <= '0;
      wr_mask_r <= 4'b0000;
    end else begin
      state_r   <= state_nxt_s;
      hready_r  <= hready_nxt_s;
      hresp_r   <= hresp_nxt_s;
      wr_pend_r <= good_s & HWRITE;
      if (good_s && HWRITE) begin
        wr_idx_r  <= idx_s;
        wr_mask_r <= mask_s;
      end
      if (good_s && !HWRITE) begin
        hrdata_r <= rd_word_s;
      end
    end
  end

  // RAM array: lane-masked write at the end of a write data phase, contents not reset
  always_ff @(posedge HCLK) begin
    if (wr_pend_r) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask_r[i]) begin
          mem_r[wr_idx_r][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule
